// File: rtl/bin2seg_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2seg_seq_if
// Brief    : Start/done request and display result bundle for bin2seg_seq.
// Revision : 1.0
// ============================================================================
interface bin2seg_seq_if #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
);
  logic [BIN_W-1:0]    bin_in;
  logic                start;
  logic                blank_lz;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;

  modport master (
    output bin_in, start, blank_lz,
    input  busy, done, overflow, bcd, seg
  );

  modport slave (
    input  bin_in, start, blank_lz,
    output busy, done, overflow, bcd, seg
  );
endinterface
`default_nettype wire

// File: rtl/bin2seg_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2seg_seq
// Brief    : Iterative double-dabble binary to multi-digit 7-segment driver.
// Revision : 1.0
// ============================================================================
module bin2seg_seq #(
  parameter int BIN_W          = 7,
  parameter int DIGITS         = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2seg_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam int         c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [6:0] c_blank = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Active-low glyphs; out-of-range digits fall back to blank.
  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 7'h40;
      4'd1:    f_glyph = 7'h79;
      4'd2:    f_glyph = 7'h24;
      4'd3:    f_glyph = 7'h30;
      4'd4:    f_glyph = 7'h19;
      4'd5:    f_glyph = 7'h12;
      4'd6:    f_glyph = 7'h02;
      4'd7:    f_glyph = 7'h78;
      4'd8:    f_glyph = 7'h00;
      4'd9:    f_glyph = 7'h10;
      default: f_glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] f_pol(input logic [6:0] s);
    f_pol = (SEG_ACTIVE_LOW != 0) ? s : ~s;
  endfunction

  state_t              r_state, w_next;
  logic [BIN_W-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_work, w_adj, r_bcd;
  logic [7*DIGITS-1:0] r_seg, w_seg;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_ovf_work, r_blank, r_done, r_ovf;
  logic                w_accept, w_last, w_lz_run;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == c_cnt_w'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CONV;
      S_CONV:  if (w_last)    w_next = S_LOAD;
      S_LOAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the top digit; a digit is leading-zero only if all above it are zero.
  always_comb begin
    w_lz_run = 1'b1;
    w_seg    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_lz_run = w_lz_run && (r_work[4*i +: 4] == 4'd0);
      if (r_ovf_work)
        w_seg[7*i +: 7] = f_pol(7'h3F);
      else if (r_blank && w_lz_run && (i != 0))
        w_seg[7*i +: 7] = c_blank;
      else
        w_seg[7*i +: 7] = f_pol(f_glyph(r_work[4*i +: 4]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_work <= 1'b0;
      r_blank    <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_seg      <= {DIGITS{c_blank}};
    end else begin
      r_done <= (r_state == S_LOAD);
      if (w_accept) begin
        r_shift    <= bus.bin_in;
        r_blank    <= bus.blank_lz;
        r_work     <= '0;
        r_ovf_work <= 1'b0;
        r_cnt      <= '0;
      end
      if (r_state == S_CONV) begin
        // The bit leaving the top digit is a carry into 10**DIGITS.
        r_work     <= {w_adj[4*DIGITS-2:0], r_shift[BIN_W-1]};
        r_shift    <= r_shift << 1;
        r_ovf_work <= r_ovf_work | w_adj[4*DIGITS-1];
        r_cnt      <= r_cnt + c_cnt_w'(1);
      end
      if (r_state == S_LOAD) begin
        r_bcd <= r_work;
        r_ovf <= r_ovf_work;
        r_seg <= w_seg;
      end
    end
  end

  assign bus.busy     = (r_state == S_CONV);
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd      = r_bcd;
  assign bus.seg      = r_seg;

endmodule
`default_nettype wire
